// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses imem and loads the IF/ID register.
// Optional stall/flush performance counters are enabled by defining IF_STAGE_PERF_CNT_EN.
module if_stage #(
    parameter int                     PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0,
    parameter logic [31:0]            NOP_INSTR = 32'h0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic [PC_WIDTH-1:0] branch_target_i,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic [31:0]         imem_data_i,
    output logic [PC_WIDTH-1:0] if_id_pc4_o,
    output logic [31:0]         if_id_instr_o,
    output logic                if_id_valid_o,
    output logic [31:0]         stall_cnt_o,
    output logic [31:0]         flush_cnt_o
);

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc4;
        logic [31:0]         instr;
        logic                valid;
    } if_id_t;

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] redirect_pc;
    if_id_t              if_id;

    // Wraps modulo 2**PC_WIDTH; redirects are forced to word alignment.
    assign pc_plus4    = pc + PC_WIDTH'(4);
    assign redirect_pc = {branch_target_i[PC_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc    <= RESET_PC;
            if_id <= '{pc4: '0, instr: NOP_INSTR, valid: 1'b0};
        end else if (flush_i) begin
            pc    <= redirect_pc;
            if_id <= '{pc4: '0, instr: NOP_INSTR, valid: 1'b0};
        end else if (!stall_i) begin
            pc    <= pc_plus4;
            if_id <= '{pc4: pc_plus4, instr: imem_data_i, valid: 1'b1};
        end
    end

    assign imem_addr_o   = pc;
    assign if_id_pc4_o   = if_id.pc4;
    assign if_id_instr_o = if_id.instr;
    assign if_id_valid_o = if_id.valid;

`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // Stalls are only counted when not overridden by a flush in the same cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_i && !flush_i && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush_i && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`else
    assign stall_cnt_o = 32'h0;
    assign flush_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed table, async-reset sequences, randomized run vs model,
// plus an 8-bit PC instance for the wrap case.
module tb_if_stage;

`ifdef IF_STAGE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, flush = 1'b0;
    logic [31:0] tgt = '0;
    logic [31:0] addr, data, pc4, instr, sc, fc;
    logic        valid;

    logic [7:0]  n_addr, n_pc4;
    logic [31:0] n_data, n_instr, n_sc, n_fc;
    logic        n_valid;

    always #5 clk = ~clk;

    // Instruction memory: word i holds i+100.
    assign data   = (addr >> 2) + 32'd100;
    assign n_data = ({24'h0, n_addr} >> 2) + 32'd100;

    if_stage #(.PC_WIDTH(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .branch_target_i(tgt), .imem_addr_o(addr), .imem_data_i(data),
        .if_id_pc4_o(pc4), .if_id_instr_o(instr), .if_id_valid_o(valid),
        .stall_cnt_o(sc), .flush_cnt_o(fc)
    );

    if_stage #(.PC_WIDTH(8), .RESET_PC(8'hF8), .NOP_INSTR(NOP)) dut_n (
        .clk_i(clk), .rst_i(rst), .stall_i(1'b0), .flush_i(1'b0),
        .branch_target_i(8'h00), .imem_addr_o(n_addr), .imem_data_i(n_data),
        .if_id_pc4_o(n_pc4), .if_id_instr_o(n_instr), .if_id_valid_o(n_valid),
        .stall_cnt_o(n_sc), .flush_cnt_o(n_fc)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: architectural view of PC, IF/ID and counters.
    logic [31:0] m_pc, m_pc4, m_instr, m_sc, m_fc;
    logic        m_valid;

    task automatic model_reset();
        m_pc = 32'h0; m_pc4 = 32'h0; m_instr = NOP; m_valid = 1'b0;
        m_sc = 32'h0; m_fc = 32'h0;
    endtask

    task automatic model_edge(input logic s, input logic f, input logic [31:0] t);
        if (f) begin
            m_pc = t & ~32'h3;
            m_pc4 = 32'h0; m_instr = NOP; m_valid = 1'b0;
            if (m_fc != 32'hFFFF_FFFF) m_fc++;
        end else if (s) begin
            if (m_sc != 32'hFFFF_FFFF) m_sc++;
        end else begin
            m_instr = m_pc / 4 + 100;
            m_pc    = m_pc + 4;
            m_pc4   = m_pc;
            m_valid = 1'b1;
        end
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, ".stall_cnt"}, sc, PERF ? m_sc : 32'h0);
        chk({tag, ".flush_cnt"}, fc, PERF ? m_fc : 32'h0);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".addr"},  addr,  m_pc);
        chk({tag, ".pc4"},   pc4,   m_pc4);
        chk({tag, ".instr"}, instr, m_instr);
        chk({tag, ".valid"}, {31'h0, valid}, {31'h0, m_valid});
        chk_counters(tag);
    endtask

    typedef struct {
        logic        s, f;
        logic [31:0] t, pc, pc4, ins;
        logic        v;
    } vec_t;
    vec_t tbl[14];

    initial begin
        // Expected state after each edge, starting from reset at pc=0.
        tbl[0]  = '{1'b0, 1'b0, 32'h0,  32'h4,  32'h4,  32'd100, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,  32'h8,  32'h8,  32'd101, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,  32'h8,  32'h8,  32'd101, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,  32'h8,  32'h8,  32'd101, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,  32'h8,  32'h8,  32'd101, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,  32'hC,  32'hC,  32'd102, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,  32'h10, 32'h10, 32'd103, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,  32'h14, 32'h14, 32'd104, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 32'h43, 32'h40, 32'h0,  NOP,     1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,  32'h44, 32'h44, 32'd116, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 32'h80, 32'h80, 32'h0,  NOP,     1'b0};
        tbl[11] = '{1'b0, 1'b1, 32'h13, 32'h10, 32'h0,  NOP,     1'b0};
        tbl[12] = '{1'b1, 1'b0, 32'h0,  32'h10, 32'h0,  NOP,     1'b0};
        tbl[13] = '{1'b0, 1'b0, 32'h0,  32'h14, 32'h14, 32'd104, 1'b1};

        // Reset state, held across edges.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_model("reset");
        chk("n_reset.addr", {24'h0, n_addr}, 32'hF8);
        chk("n_reset.cnt", n_sc | n_fc, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            stall = tbl[i].s; flush = tbl[i].f; tgt = tbl[i].t;
            @(posedge clk);
            model_edge(tbl[i].s, tbl[i].f, tbl[i].t);
            #1;
            chk($sformatf("tbl%0d.addr", i),  addr,  tbl[i].pc);
            chk($sformatf("tbl%0d.pc4", i),   pc4,   tbl[i].pc4);
            chk($sformatf("tbl%0d.instr", i), instr, tbl[i].ins);
            chk($sformatf("tbl%0d.valid", i), {31'h0, valid}, {31'h0, tbl[i].v});
            chk_counters($sformatf("tbl%0d", i));
            if (i == 0) begin
                chk("n_wrap0.addr", {24'h0, n_addr}, 32'hFC);
                chk("n_wrap0.pc4",  {24'h0, n_pc4},  32'hFC);
            end
            if (i == 1) begin
                chk("n_wrap1.addr",  {24'h0, n_addr}, 32'h00);
                chk("n_wrap1.pc4",   {24'h0, n_pc4},  32'h00);
                chk("n_wrap1.instr", n_instr, 32'd163);
                chk("n_wrap1.valid", {31'h0, n_valid}, 32'h1);
            end
        end

        // Async reset pulsed between edges while stalled.
        stall = 1'b1; flush = 1'b0;
        @(posedge clk);
        model_edge(1'b1, 1'b0, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk_model("async_rst");
        // Redirect pending while in reset is lost.
        stall = 1'b0; flush = 1'b1; tgt = 32'h200;
        @(posedge clk);
        #1;
        rst = 1'b1;
        flush = 1'b0;
        chk_model("rst_flush");
        @(posedge clk);
        model_edge(1'b0, 1'b0, 32'h0);
        #1;
        chk_model("post_rst");

        // Randomized run against the model.
        for (int i = 0; i < 400; i++) begin
            flush = ($urandom_range(0, 99) < 15);
            stall = ($urandom_range(0, 99) < 25);
            tgt   = {22'h0, 10'($urandom)};
            @(posedge clk);
            model_edge(stall, flush, tgt);
            #1;
            chk_model($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
